// File: rtl/stack_ctrl_if.sv
// Stack RAM request bus between stack_ctrl (master) and RAM (slave).
interface stack_ctrl_if;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/stack_ctrl.sv
// Downward-growing stack sequencer with SP/overflow strobes for the CSR block.
// Optional: STACK_UNDERFLOW_TRAP_EN flags pop-on-empty as an overflow event.
module stack_ctrl #(
  parameter logic [10:0] STACK_TOP   = 11'h7FF,
  parameter logic [10:0] STACK_LIMIT = 11'h700
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_req,
  input  logic [7:0]  push_data,
  input  logic        pop_req,
  output logic [7:0]  pop_data,
  output logic        pop_valid,
  input  logic        sp_load,
  input  logic [10:0] sp_load_val,
  output logic        busy,
  stack_ctrl_if.master mem,
  output logic [10:0] sp,
  output logic [2:0]  sp_msb,
  output logic        sp_msb_en,
  output logic        st_ovf,
  output logic        st_ovf_en
);

  localparam logic [10:0] SP_FULL = STACK_LIMIT - 11'd1;

  typedef enum logic [1:0] {
    IDLE,
    PUSH_WR,
    POP_RD
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] sp_q, sp_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [7:0]  pdata_q, pdata_d;
  logic        pvalid_q, pvalid_d;
  logic        ovf_q, ovf_d;
  logic        ovf_en_q, ovf_en_d;
  logic        msb_en_q, msb_en_d;
  logic        init_q, init_d;

  logic do_load;
  logic do_push;
  logic do_pop;

  assign do_load = sp_load;
  assign do_push = push_req & ~sp_load;
  assign do_pop  = pop_req & ~push_req & ~sp_load;

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    re_d     = re_q;
    pdata_d  = pdata_q;
    pvalid_d = 1'b0;
    ovf_d    = ovf_q;
    ovf_en_d = 1'b0;
    init_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          do_load: sp_d = sp_load_val;
          do_push: begin
            if (sp_q == SP_FULL) begin
              ovf_d    = 1'b1;
              ovf_en_d = 1'b1;
            end else begin
              state_d = PUSH_WR;
              addr_d  = sp_q;
              wdata_d = push_data;
              we_d    = 1'b1;
            end
          end
          do_pop: begin
            if (sp_q == STACK_TOP) begin
              pvalid_d = 1'b1;
              pdata_d  = 8'h00;
`ifdef STACK_UNDERFLOW_TRAP_EN
              ovf_d    = 1'b1;
              ovf_en_d = 1'b1;
`endif
            end else begin
              state_d = POP_RD;
              addr_d  = sp_q + 11'd1;
              re_d    = 1'b1;
            end
          end
          default: ;
        endcase
      end
      PUSH_WR: begin
        if (mem.mem_ack) begin
          state_d  = IDLE;
          we_d     = 1'b0;
          sp_d     = sp_q - 11'd1;
          ovf_d    = 1'b0;
          ovf_en_d = 1'b1;
        end
      end
      POP_RD: begin
        if (mem.mem_ack) begin
          state_d  = IDLE;
          re_d     = 1'b0;
          sp_d     = sp_q + 11'd1;
          pdata_d  = mem.mem_rdata;
          pvalid_d = 1'b1;
          ovf_d    = 1'b0;
          ovf_en_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // init_q forces one resync pulse after reset
    msb_en_d = init_q | (sp_d[10:8] != sp_q[10:8]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sp_q     <= STACK_TOP;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      ovf_en_q <= 1'b0;
      msb_en_q <= 1'b0;
      init_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      ovf_q    <= ovf_d;
      ovf_en_q <= ovf_en_d;
      msb_en_q <= msb_en_d;
      init_q   <= init_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign sp            = sp_q;
  assign sp_msb        = sp_q[10:8];
  assign sp_msb_en     = msb_en_q;
  assign st_ovf        = ovf_q;
  assign st_ovf_en     = ovf_en_q;
  assign pop_data      = pdata_q;
  assign pop_valid     = pvalid_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_re    = re_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: op table, RAM model, pop-data scoreboard.
// Build with +define+STACK_UNDERFLOW_TRAP_EN to match a trap-enabled DUT.
module tb_stack_ctrl;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_BOTH = 2'd3;

`ifdef STACK_UNDERFLOW_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    logic [10:0] val;
    int          lat;
    logic [10:0] exp_sp;
    logic        exp_oen;
    logic        exp_ovf;
    logic        exp_msb;
    logic        exp_we;
    logic        exp_re;
    logic        exp_pv;
    logic [7:0]  exp_pd;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        push_req;
  logic [7:0]  push_data;
  logic        pop_req;
  logic [7:0]  pop_data;
  logic        pop_valid;
  logic        sp_load;
  logic [10:0] sp_load_val;
  logic        busy;
  logic [10:0] sp;
  logic [2:0]  sp_msb;
  logic        sp_msb_en;
  logic        st_ovf;
  logic        st_ovf_en;

  stack_ctrl_if mif ();

  stack_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .push_req    (push_req),
    .push_data   (push_data),
    .pop_req     (pop_req),
    .pop_data    (pop_data),
    .pop_valid   (pop_valid),
    .sp_load     (sp_load),
    .sp_load_val (sp_load_val),
    .busy        (busy),
    .mem         (mif.master),
    .sp          (sp),
    .sp_msb      (sp_msb),
    .sp_msb_en   (sp_msb_en),
    .st_ovf      (st_ovf),
    .st_ovf_en   (st_ovf_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [2048];
  logic [7:0] exp_q [$];
  int   ack_lat = 1;
  int   held_cnt = 0;

  logic ovf_seen, ovf_val, msb_seen, we_seen, re_seen;
  int   msb_cnt = 0;
  logic prev_held = 1'b0;
  logic [10:0] prev_addr;
  logic [7:0]  prev_wdata;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic clear_flags();
    ovf_seen = 1'b0;
    ovf_val  = 1'b0;
    msb_seen = 1'b0;
    we_seen  = 1'b0;
    re_seen  = 1'b0;
  endtask

  // RAM model: holds off ack for ack_lat cycles of a held request
  always @(negedge clk) begin
    if (reset || !(mif.mem_we || mif.mem_re)) begin
      held_cnt    = 0;
      mif.mem_ack = 1'b0;
    end else begin
      held_cnt++;
      if (held_cnt >= ack_lat) begin
        mif.mem_ack = 1'b1;
        if (mif.mem_we) ram[mif.mem_addr] = mif.mem_wdata;
        mif.mem_rdata = ram[mif.mem_addr];
      end else begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 8'hEE;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (st_ovf_en) begin
      ovf_seen = 1'b1;
      ovf_val  = st_ovf;
    end
    if (sp_msb_en) begin
      msb_seen = 1'b1;
      msb_cnt++;
    end
    if (mif.mem_we) we_seen = 1'b1;
    if (mif.mem_re) re_seen = 1'b1;
    if (pop_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected act=%0h exp=none", pop_data);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", {24'd0, pop_data}, {24'd0, e});
      end
    end
    if (mif.mem_we || mif.mem_re) begin
      chk("we_re_excl", {31'd0, mif.mem_we & mif.mem_re}, 32'd0);
      if (prev_held) begin
        chk("addr_stable", {21'd0, mif.mem_addr}, {21'd0, prev_addr});
        chk("wdata_stable", {24'd0, mif.mem_wdata},
            {24'd0, prev_wdata});
      end
      prev_held  = 1'b1;
      prev_addr  = mif.mem_addr;
      prev_wdata = mif.mem_wdata;
    end else begin
      prev_held = 1'b0;
    end
  end

  task automatic apply(input vec_t v, input int idx);
    bit done;
    string s;
    @(posedge clk);
    #1;
    clear_flags();
    ack_lat = v.lat;
    case (v.op)
      OP_LOAD: begin
        sp_load     = 1'b1;
        sp_load_val = v.val;
      end
      OP_PUSH: begin
        push_req  = 1'b1;
        push_data = v.data;
      end
      OP_POP: pop_req = 1'b1;
      default: begin
        push_req  = 1'b1;
        pop_req   = 1'b1;
        push_data = v.data;
      end
    endcase
    if (v.exp_pv) exp_q.push_back(v.exp_pd);
    @(posedge clk);
    #1;
    sp_load  = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    s = $sformatf("v%0d", idx);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout act=busy exp=idle", s);
    end
    @(posedge clk);
    #1;
    chk({s, "_sp"}, {21'd0, sp}, {21'd0, v.exp_sp});
    chk({s, "_spmsb"}, {29'd0, sp_msb}, {29'd0, v.exp_sp[10:8]});
    chk({s, "_ovf_en"}, {31'd0, ovf_seen}, {31'd0, v.exp_oen});
    if (v.exp_oen)
      chk({s, "_ovf"}, {31'd0, ovf_val}, {31'd0, v.exp_ovf});
    chk({s, "_msb_en"}, {31'd0, msb_seen}, {31'd0, v.exp_msb});
    chk({s, "_we"}, {31'd0, we_seen}, {31'd0, v.exp_we});
    chk({s, "_re"}, {31'd0, re_seen}, {31'd0, v.exp_re});
  endtask

  function automatic vec_t mk(
    input logic [1:0] op, input logic [7:0] d, input logic [10:0] val,
    input int lat, input logic [10:0] xsp, input logic oen,
    input logic ov, input logic msb, input logic we, input logic re,
    input logic pv, input logic [7:0] pd);
    vec_t v;
    v.op = op;       v.data = d;      v.val = val;
    v.lat = lat;     v.exp_sp = xsp;  v.exp_oen = oen;
    v.exp_ovf = ov;  v.exp_msb = msb; v.exp_we = we;
    v.exp_re = re;   v.exp_pv = pv;   v.exp_pd = pd;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    bit done;
    int held;

    tbl[0]  = mk(OP_POP,  8'h00, 11'h000, 1, 11'h7FF,
                 1, 0, 0, 0, 1, 1, 8'hA5);
    tbl[1]  = mk(OP_LOAD, 8'h00, 11'h700, 1, 11'h700,
                 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[2]  = mk(OP_PUSH, 8'h11, 11'h000, 2, 11'h6FF,
                 1, 0, 1, 1, 0, 0, 8'h00);
    tbl[3]  = mk(OP_PUSH, 8'h22, 11'h000, 1, 11'h6FF,
                 1, 1, 0, 0, 0, 0, 8'h00);
    tbl[4]  = mk(OP_POP,  8'h00, 11'h000, 1, 11'h700,
                 1, 0, 1, 0, 1, 1, 8'h11);
    tbl[5]  = mk(OP_BOTH, 8'h33, 11'h000, 2, 11'h6FF,
                 1, 0, 1, 1, 0, 0, 8'h00);
    tbl[6]  = mk(OP_POP,  8'h00, 11'h000, 4, 11'h700,
                 1, 0, 1, 0, 1, 1, 8'h33);
    tbl[7]  = mk(OP_LOAD, 8'h00, 11'h7FF, 1, 11'h7FF,
                 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[8]  = mk(OP_POP,  8'h00, 11'h000, 1, 11'h7FF,
                 TRAP, 1, 0, 0, 0, 1, 8'h00);
    tbl[9]  = mk(OP_LOAD, 8'h00, 11'h0FF, 1, 11'h0FF,
                 0, 0, 1, 0, 0, 0, 8'h00);
    tbl[10] = mk(OP_PUSH, 8'h5A, 11'h000, 1, 11'h0FE,
                 1, 0, 0, 1, 0, 0, 8'h00);
    tbl[11] = mk(OP_PUSH, 8'hC3, 11'h000, 3, 11'h0FD,
                 1, 0, 0, 1, 0, 0, 8'h00);
    tbl[12] = mk(OP_POP,  8'h00, 11'h000, 2, 11'h0FE,
                 1, 0, 0, 0, 1, 1, 8'hC3);
    tbl[13] = mk(OP_POP,  8'h00, 11'h000, 1, 11'h0FF,
                 1, 0, 0, 0, 1, 1, 8'h5A);
    tbl[14] = mk(OP_LOAD, 8'h00, 11'h7FE, 1, 11'h7FE,
                 0, 0, 1, 0, 0, 0, 8'h00);

    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    reset         = 1'b1;
    push_req      = 1'b0;
    push_data     = 8'h00;
    pop_req       = 1'b0;
    sp_load       = 1'b0;
    sp_load_val   = 11'h000;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 8'h00;
    clear_flags();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sp", {21'd0, sp}, 32'h7FF);
    chk("rst_spmsb", {29'd0, sp_msb}, 32'd7);
    chk("rst_we", {31'd0, mif.mem_we}, 32'd0);
    chk("rst_re", {31'd0, mif.mem_re}, 32'd0);
    chk("rst_addr", {21'd0, mif.mem_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pv", {31'd0, pop_valid}, 32'd0);
    chk("rst_ovf_en", {31'd0, st_ovf_en}, 32'd0);
    chk("rst_ovf", {31'd0, st_ovf}, 32'd0);
    chk("rst_msb_en", {31'd0, sp_msb_en}, 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    msb_cnt = 0;
    repeat (6) @(negedge clk);
    chk("init_msb_pulses", msb_cnt, 32'd1);

    // push A5 with 3-cycle ack, pop_req while busy
    @(posedge clk);
    #1;
    clear_flags();
    ack_lat   = 3;
    push_req  = 1'b1;
    push_data = 8'hA5;
    @(posedge clk);
    #1;
    push_req = 1'b0;
    pop_req  = 1'b1;
    held = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (i == 1) pop_req = 1'b0;
      if (mif.mem_we) begin
        held++;
        chk("pushA5_addr", {21'd0, mif.mem_addr}, 32'h7FF);
        chk("pushA5_wdata", {24'd0, mif.mem_wdata}, 32'hA5);
        chk("pushA5_busy", {31'd0, busy}, 32'd1);
      end else begin
        done = 1'b1;
      end
    end
    pop_req = 1'b0;
    chk("pushA5_held", held, 32'd3);
    @(posedge clk);
    #1;
    chk("pushA5_sp", {21'd0, sp}, 32'h7FE);
    chk("pushA5_busy_end", {31'd0, busy}, 32'd0);
    chk("pushA5_ovf_en", {31'd0, ovf_seen}, 32'd1);
    chk("pushA5_ovf", {31'd0, ovf_val}, 32'd0);
    chk("busy_pop_ignored", {31'd0, re_seen}, 32'd0);

    for (int i = 0; i < 15; i++) apply(tbl[i], i);

    // reset during PUSH_WR abandons the write
    @(posedge clk);
    #1;
    ack_lat   = 1000;
    push_req  = 1'b1;
    push_data = 8'h77;
    @(posedge clk);
    #1;
    push_req = 1'b0;
    @(negedge clk);
    chk("abort_we_pre", {31'd0, mif.mem_we}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_we", {31'd0, mif.mem_we}, 32'd0);
    chk("abort_sp", {21'd0, sp}, 32'h7FF);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ram", {24'd0, ram[11'h7FE]}, 32'd0);
    ack_lat = 1;
    repeat (4) @(posedge clk);

    // pop on empty straight after reset
    apply(tbl[8], 99);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Stack-pointer and stack-memory sequencer that sits directly upstream of the control/status register block. It executes single-byte PUSH/POP requests from the instruction decoder against stack RAM, using a req/ack handshake. It maintains an 11-bit stack pointer and produces the SP[10:8] update and stack-overflow flag strobes consumed by the control/status register. The stack grows downward from STACK_TOP toward STACK_LIMIT.

Parameters:
STACK_TOP, 11'h7FF, reset/empty value of SP; first push writes here
STACK_LIMIT, 11'h700, lowest writable address; SP == STACK_LIMIT-1 means full

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
push_req  in  1  push request, sampled only when busy=0
push_data  in  8  byte to push, sampled with push_req
pop_req  in  1  pop request, sampled only when busy=0
pop_data  out  8  popped byte, registered
pop_valid  out  1  one-cycle pulse, pop_data valid
sp_load  in  1  load SP from sp_load_val, sampled only when busy=0
sp_load_val  in  11  new SP value
busy  out  1  transaction in flight; new requests ignored
mem_addr  out  11  stack RAM address
mem_wdata  out  8  stack RAM write data
mem_we  out  1  write request, held until mem_ack
mem_re  out  1  read request, held until mem_ack
mem_ack  in  1  RAM completion; read data valid in same cycle
mem_rdata  in  8  RAM read data
sp  out  11  current stack pointer
sp_msb  out  3  SP[10:8] for control reg (SP_MSB10..8)
sp_msb_en  out  1  one-cycle strobe: write sp_msb into control reg
st_ovf  out  1  stack overflow/underflow value for status reg
st_ovf_en  out  1  one-cycle strobe: write st_ovf into status reg

Behaviour:
- Reset: SP=STACK_TOP, state IDLE. All outputs 0 except sp=STACK_TOP and sp_msb=STACK_TOP[10:8]. Reset asserted mid-transaction abandons it: mem_we/mem_re are 0 in the cycle after the reset edge, and SP is not updated.
- First cycle after reset deasserts: sp_msb_en=1 (one-time sync pulse so the control reg matches SP).
- States: IDLE, PUSH_WR, POP_RD. busy=1 exactly when state != IDLE.
- IDLE priority: sp_load > push_req > pop_req. Lower-priority requests in the same cycle are dropped; the requester must re-issue them.
- sp_load: SP<=sp_load_val on the next edge; no memory access; busy stays 0.
- Push when SP != STACK_LIMIT-1:
  - Accept at edge T; mem_addr=SP, mem_wdata=push_data, mem_we=1 from T+1 until the ack cycle.
  - On the ack edge: SP<=SP-1, return to IDLE, st_ovf_en pulse with st_ovf=0.
- Push when SP == STACK_LIMIT-1 (full): no RAM access, SP unchanged, busy stays 0; next cycle st_ovf=1, st_ovf_en=1.
- Pop when SP != STACK_TOP:
  - Accept at T; mem_addr=SP+1, mem_re=1 from T+1 until ack.
  - On the ack edge: SP<=SP+1, pop_data<=mem_rdata, and pop_valid=1 for the following cycle.
  - st_ovf_en pulse with st_ovf=0.
- Pop when SP == STACK_TOP (empty): handled per the optional feature.
- SP arithmetic is 11-bit modulo. Wrap is only reachable via sp_load and is not checked.
- sp_msb_en: pulses for one cycle in the cycle after any SP update whose bit [10:8] value differs from the previous SP; sp_msb then shows the new bits.
- st_ovf holds its last written value between strobes.
- mem_we and mem_re are never both 1. mem_addr and mem_wdata are stable while a request is held.
- mem_ack while IDLE is ignored.

Optional Feature:
STACK_UNDERFLOW_TRAP_EN
- Defined: pop on empty performs no RAM access, busy stays 0, SP unchanged. Next cycle st_ovf=1, st_ovf_en=1, pop_valid=1, pop_data=8'h00.
- Undefined: pop on empty performs no RAM access and no flag update (st_ovf_en=0). Next cycle pop_valid=1, pop_data=8'h00.

Test Plan:
- Reset then idle: sp=7FF, sp_msb=3'b111, sp_msb_en pulses once in the first cycle after reset drops; all mem signals 0.
- Push 8'hA5 with mem_ack delayed 3 cycles:
  - mem_we=1, mem_addr=7FF, mem_wdata=A5 held 3 cycles, busy=1.
  - After ack: sp=7FE, st_ovf_en with st_ovf=0.
  - A pop_req issued while busy is ignored.
- Pop after that push, ack same cycle as request: mem_re=1 with mem_addr=7FF; pop_valid=1 with pop_data=A5; sp=7FF.
- sp_load 11'h700 then push 8'h11: write at 700, sp=6FF.
  - sp_msb_en pulses after the load (111->111? no, 111->111 is unchanged, so no pulse after the load).
  - sp_msb_en pulses after the push (111->110).
  - A further push: no mem_we, st_ovf=1, st_ovf_en=1, sp=6FF.
- Simultaneous push_req and pop_req in IDLE: only the push executes; sp decrements by 1; no mem_re.
- Reset asserted during PUSH_WR before ack: the next cycle shows mem_we=0, sp=7FF, busy=0. Pop on empty: pop_data=00 and pop_valid=1, with st_ovf=1 only if STACK_UNDERFLOW_TRAP_EN is defined.
